// File: rtl/sftm_sched_pkg.sv
// sftm_sched_pkg: shared types and width helpers for the sftm job scheduler
package sftm_sched_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_RUN} sched_state_t;
    function automatic int tag_w(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction
    function automatic int job_w(input int pof, input int pif, input int mult_width);
        return pof * pif * mult_width;
    endfunction
endpackage

// File: rtl/sftm_job_scheduler_if.sv
// sftm_job_scheduler_if: requester-side and core-side handshake bundle of the scheduler
interface sftm_job_scheduler_if #(
    parameter int NREQ = 4,
    parameter int JW   = sftm_sched_pkg::job_w(4, 12, 32)
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*JW-1:0] req_mults_flat;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    done_valid;
    logic               core_job_valid;
    logic [JW-1:0]      core_mults_flat;
    logic               core_start;
    logic               core_busy;
    logic               core_job_done;
    modport master (
        output req_valid, req_mults_flat, core_busy, core_job_done,
        input  req_ready, done_valid, core_job_valid, core_mults_flat, core_start
    );
    modport slave (
        input  req_valid, req_mults_flat, core_busy, core_job_done,
        output req_ready, done_valid, core_job_valid, core_mults_flat, core_start
    );
endinterface

// File: rtl/sched_tag_fifo.sv
// sched_tag_fifo: synchronous FIFO of requester tags, any depth, concurrent push/pop
module sched_tag_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic          do_push, do_pop;
    assign full    = cnt == CW'(DEPTH);
    assign empty   = cnt == '0;
    assign head    = mem[rp];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= (wp == PW'(DEPTH - 1)) ? '0 : wp + 1'b1;
            if (do_pop) rp <= (rp == PW'(DEPTH - 1)) ? '0 : rp + 1'b1;
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end
endmodule

// File: rtl/sftm_job_scheduler.sv
// sftm_job_scheduler: round-robin job admission, credit flow control and start sequencing for one sftm_core
module sftm_job_scheduler
    import sftm_sched_pkg::*;
#(
    parameter int  NREQ       = 4,
    parameter int  POF        = 4,
    parameter int  PIF        = 12,
    parameter int  MULT_WIDTH = 32,
    parameter int  FIFO_DEPTH = 8,
    localparam int JW         = job_w(POF, PIF, MULT_WIDTH),
    localparam int TAG_W      = tag_w(NREQ),
    localparam int QW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sched_en,
    sftm_job_scheduler_if.slave  bus,
    output logic [QW-1:0]        queued,
    output logic                 idle,
    output logic                 err_orphan
);
    sched_state_t     state_q, state_d;
    logic [TAG_W-1:0] rr_ptr, rr_next, gnt_idx, off, tag_head;
    logic [TAG_W:0]   gsum;
    logic [NREQ-1:0]  dbl;
    logic [QW:0]      occ;
    logic             gnt_any, allow, hs, pop, tag_full, tag_empty;
    // rotate requests so bit 0 is rr_ptr, then take the first set bit
    always_comb begin
        dbl     = NREQ'({bus.req_valid, bus.req_valid} >> rr_ptr);
        off     = '0;
        gnt_any = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (dbl[i]) begin
                off     = TAG_W'(i);
                gnt_any = 1'b1;
            end
        end
        gsum    = {1'b0, rr_ptr} + {1'b0, off};
        gnt_idx = (gsum >= (TAG_W+1)'(NREQ)) ? TAG_W'(gsum - (TAG_W+1)'(NREQ)) : TAG_W'(gsum);
    end
    // a start issued this cycle frees its credit for a same-cycle grant
    assign occ            = {1'b0, queued} + (QW+1)'(bus.core_job_valid) - (QW+1)'(bus.core_start);
    assign allow          = sched_en && occ < (QW+1)'(FIFO_DEPTH) && !tag_full;
    assign hs             = allow && gnt_any;
    assign rr_next        = (gnt_idx == TAG_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    assign bus.req_ready  = hs ? NREQ'(1) << gnt_idx : '0;
    assign pop            = bus.core_job_done && !tag_empty;
    assign bus.done_valid = pop ? NREQ'(1) << tag_head : '0;
    assign idle           = state_q == ST_IDLE && queued == '0 && !bus.core_job_valid && tag_empty;
    always_comb begin
        state_d        = state_q;
        bus.core_start = 1'b0;
        unique case (state_q)
            ST_IDLE:
                if (queued != '0 && !bus.core_busy) begin
                    bus.core_start = 1'b1;
                    state_d        = ST_ARMED;
                end
            ST_ARMED: state_d = ST_RUN;
            ST_RUN:
                if (bus.core_job_done) begin
                    bus.core_start = queued != '0;
                    state_d        = (queued != '0) ? ST_ARMED : ST_IDLE;
                end
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q             <= ST_IDLE;
            rr_ptr              <= '0;
            queued              <= '0;
            bus.core_job_valid  <= 1'b0;
            bus.core_mults_flat <= '0;
            err_orphan          <= 1'b0;
        end else begin
            state_q            <= state_d;
            queued             <= queued + QW'(bus.core_job_valid) - QW'(bus.core_start);
            bus.core_job_valid <= hs;
            err_orphan         <= err_orphan | (bus.core_job_done && tag_empty);
            if (hs) begin
                rr_ptr              <= rr_next;
                bus.core_mults_flat <= bus.req_mults_flat[gnt_idx*JW +: JW];
            end
        end
    end
    sched_tag_fifo #(
        .W     (TAG_W),
        .DEPTH (FIFO_DEPTH + 1)
    ) u_tags (
        .clk   (clk),
        .rst   (rst),
        .push  (hs),
        .pop   (pop),
        .din   (gnt_idx),
        .full  (tag_full),
        .empty (tag_empty),
        .head  (tag_head)
    );
endmodule

// File: doc/sftm_job_scheduler.md
# sftm_job_scheduler

Round-robin job scheduler in front of one `sftm_core`. It arbitrates `NREQ` requesters, each offering an `assigned_mults` job, and pushes the granted job into the core's job FIFO with flow control from a credit counter. It sequences the core's `start` pulses against `busy`/`job_done` and routes each completion back to the requester that issued that job.

## Interface
- `NREQ`, 4, number of requesters (≥2)
- `POF`, 4, SCU rows
- `PIF`, 12, SCU columns
- `MULT_WIDTH`, 32, per-SCU multiplier-count field width
- `FIFO_DEPTH`, 8, depth of the core job FIFO (credit limit)
- `JW` (localparam), `POF*PIF*MULT_WIDTH`, job payload width
- `TAG_W` (localparam), `$clog2(NREQ)`
---
- `clk` in 1: single clock; all logic on the rising edge
- `rst` in 1: synchronous, active-high reset
- `sched_en` in 1: 0 blocks new grants; queued and running jobs still drain
- `req_valid` in NREQ: per-requester job offer
- `req_mults_flat` in NREQ*JW: requester i payload at `[i*JW +: JW]`
- `req_ready` out NREQ: one-hot grant; handshake completes when valid&&ready
- `done_valid` out NREQ: one-hot, 1-cycle pulse to the job's owner
- `core_job_valid` out 1: to core `job_valid`
- `core_mults_flat` out JW: to core `assigned_mults_flat`
- `core_start` out 1: to core `start`
- `core_busy` in 1: from core `busy`
- `core_job_done` in 1: from core `job_done`
- `queued` out $clog2(FIFO_DEPTH+1): jobs in the core FIFO not yet started
- `idle` out 1: nothing queued, nothing running, no push pending
- `err_orphan` out 1: sticky; `core_job_done` arrived while the tag FIFO was empty

## Operation
- **Admission.** Grant is allowed when `sched_en && (queued + core_job_valid) < FIFO_DEPTH` and the tag FIFO is not full.
  - The highest-priority valid requester, starting from `rr_ptr`, gets `req_ready` combinationally.
  - On the handshake, `rr_ptr` becomes grant+1 mod NREQ; otherwise `rr_ptr` holds.
  - Requesters hold `valid` and payload until `ready`. `req_ready` never asserts when blocked.
- **Push.** On the handshake, the payload is registered to `core_mults_flat` and `core_job_valid` pulses for one cycle.
  - The grant index is pushed into the tag FIFO in the same cycle.
  - `core_mults_flat` holds its last value otherwise.
- **Queue count.** `queued_next = queued + core_job_valid - core_start`. A simultaneous push and start leaves it unchanged.
- **Start FSM**:
  - IDLE: if `queued>0 && !core_busy`, pulse `core_start` and go to ARMED.
  - ARMED: one cycle while core `busy` rises; `core_start`=0; go to RUN.
  - RUN: wait for `core_job_done`. On `core_job_done`, the core has already cleared `busy`:
    - if `queued>0`, pulse `core_start` in the same cycle and go to ARMED;
    - else go to IDLE.
- **Completion.** `core_job_done` pops the tag FIFO head and asserts `done_valid[tag]` in the same cycle (combinational from the head). Completion order equals start order, which equals push order.
- **Orphan completion.** `core_job_done` with the tag FIFO empty sets `err_orphan` (cleared only by `rst`) and produces no `done_valid`.
- **Idle.** `idle = (state==IDLE) && queued==0 && !core_job_valid && tag_fifo_empty`.

## Timing
- Reset values: `req_ready`=0, `done_valid`=0, `core_job_valid`=0, `core_mults_flat`=0, `core_start`=0, `queued`=0, `idle`=1, `err_orphan`=0, `rr_ptr`=0, FSM=IDLE, tag FIFO empty.
- Handshake at cycle t:
  - `core_job_valid` at t+1;
  - `queued` increments at t+2;
  - earliest `core_start` at t+2, which satisfies the core FIFO's one-cycle write-to-read latency.
- Start is never issued in two consecutive cycles; at most one start per job.
- `done_valid` has zero latency from `core_job_done`.
- Back-to-back requests from one requester: at most one grant per cycle, NREQ grants per NREQ cycles under full load.
- Full: at `queued + core_job_valid == FIFO_DEPTH`, all `req_ready`=0 until a start frees a credit; a grant is possible in the same cycle as that `core_start`.
- The tag FIFO holds `FIFO_DEPTH+1` entries (queued jobs plus the running job) and cannot overflow under the admission rule.
- `rst` mid-operation: all state is cleared next edge and in-flight tags are discarded. The core must share `rst` (via a polarity adapter to its `rst_n`).

## Structure
- Package `sftm_sched_pkg`: FSM state enum (IDLE/ARMED/RUN), `TAG_W`/`JW` helper functions.
- Sub-module `sched_tag_fifo`: synchronous FIFO, width `TAG_W`, depth `FIFO_DEPTH+1`, with push/pop/full/empty/head; simultaneous push and pop is supported.
- The round-robin arbiter is inline (double-width request mask, first-one search).

## Test plan
- **Single job.** `req_valid[2]`=1 at t0 → `req_ready[2]`=1 at t0, `core_job_valid` at t1, `core_start` at t2; then `core_job_done` → `done_valid`=4'b0100 same cycle, `idle`=1 next cycle.
- **Fairness.** All four requesters valid continuously, `rr_ptr`=0 → grants 0,1,2,3,0,… each exactly once per 4 grants.
- **Credit full.** Core held busy, 9 offers → 8 grants accepted, 9th `req_ready`=0. Next `core_start` → 9th granted that cycle.
- **Back-to-back.** `core_job_done` with `queued`=2 → `core_start` in the same cycle, `queued` goes 2→1, completions return tags in push order.
- **Pause.** `sched_en`=0 with 3 queued → no grants; all 3 run and complete; `idle`=1.
- **Reset and orphan.** `rst` pulse mid-RUN → all outputs at reset values next cycle. A spurious `core_job_done` afterwards → `err_orphan`=1, no `done_valid`.
